// File: rtl/rgb_led_pkg.sv
// Shared types and helpers for the RGB LED array output stage.
package rgb_led_pkg;

    typedef enum logic [1:0] {
        StGuess,
        StReveal,
        StHistory
    } state_e;

    localparam logic [31:0] COLOR_OFF = '0;

    // LSB position of LED idx inside a packed colour bus
    function automatic int unsigned color_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running brightness PWM: counter wraps at 2^PWM_BITS-2 so all-ones is constant on.
module pwm_gen #(
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                pwm_on
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'((1 << PWM_BITS) - 2);

    logic [PWM_BITS-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign pwm_on = (cnt_q < brightness);

endmodule

// File: rtl/rgb_led_array_ctrl.sv
// RGB LED array driver: GUESS (blinking cursor), REVEAL animation and HISTORY display,
// with global PWM brightness and a registered output.
module rgb_led_array_ctrl
    import rgb_led_pkg::*;
#(
    parameter int unsigned NUM_LEDS    = 4,
    parameter int unsigned COLOR_W     = 3,
    parameter int unsigned BLINK_HALF  = 25_000_000,
    parameter int unsigned REVEAL_STEP = 50_000_000,
    parameter int unsigned PWM_BITS    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          blink_enable,
    input  logic [$clog2(NUM_LEDS)-1:0]   cursor,
    input  logic [NUM_LEDS*COLOR_W-1:0]   guess_rgb,
    input  logic [NUM_LEDS*COLOR_W-1:0]   history_rgb,
    input  logic                          history_load,
    input  logic [PWM_BITS-1:0]           brightness,
    output logic [NUM_LEDS*COLOR_W-1:0]   rgb_out,
    output logic                          reveal_busy
);

    localparam int unsigned CUR_W   = $clog2(NUM_LEDS);
    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned STEP_W  = (REVEAL_STEP > 1) ? $clog2(REVEAL_STEP) : 1;
    localparam int unsigned RC_W    = $clog2(NUM_LEDS + 1);

    localparam logic [COLOR_W-1:0] OFF        = COLOR_W'(COLOR_OFF);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(REVEAL_STEP - 1);
    localparam logic [RC_W-1:0]    RC_FULL    = RC_W'(NUM_LEDS);

    state_e                       state_q, state_d;
    logic [BLINK_W-1:0]           blink_cnt_q, blink_cnt_d;
    logic                         blink_on_q, blink_on_d;
    logic [STEP_W-1:0]            step_q, step_d;
    logic [RC_W-1:0]              rc_q, rc_d;
    logic [NUM_LEDS*COLOR_W-1:0]  rgb_q, rgb_d;
    logic                         pwm_on;

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gen (
        .clk        (clk),
        .rst        (rst),
        .brightness (brightness),
        .pwm_on     (pwm_on)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StGuess;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            step_q      <= '0;
            rc_q        <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            step_q      <= step_d;
            rc_q        <= rc_d;
            rgb_q       <= rgb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        rc_d    = rc_q;
        if (blink_enable) begin
            state_d = StGuess;
        end else if (history_load) begin
            state_d = StReveal;
            step_d  = '0;
            rc_d    = RC_W'(1);
        end else begin
            case (state_q)
                StGuess: state_d = StHistory;
                StReveal: begin
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (rc_q < RC_FULL) rc_d = rc_q + 1'b1;
                        else                state_d = StHistory;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Blink state holds its reset value outside GUESS, so every entry starts cursor-visible
    always_comb begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if (state_q == StGuess && state_d == StGuess) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_on_d = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_on_d  = blink_on_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_led
        localparam int unsigned LSB = color_lsb(g, COLOR_W);
        logic [COLOR_W-1:0] col;

        always_comb begin
            case (state_q)
                StGuess:   col = (cursor == CUR_W'(g) && !blink_on_q) ? OFF
                                                                       : guess_rgb[LSB +: COLOR_W];
                StReveal:  col = (rc_q > RC_W'(g)) ? history_rgb[LSB +: COLOR_W] : OFF;
                StHistory: col = history_rgb[LSB +: COLOR_W];
                default:   col = OFF;
            endcase
        end

        assign rgb_d[LSB +: COLOR_W] = pwm_on ? col : OFF;
    end

    assign rgb_out     = rgb_q;
    assign reveal_busy = (state_q == StReveal);

endmodule

// File: tb/tb_rgb_led_array_ctrl.sv
// Directed bench for rgb_led_array_ctrl with a time-based reference model feeding a scoreboard.
module tb_rgb_led_array_ctrl;

    localparam int NL = 4;
    localparam int CW = 3;
    localparam int BH = 4;
    localparam int RS = 3;
    localparam int PB = 2;

    typedef struct {
        logic [NL*CW-1:0] rgb;
        logic             busy;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             blink_enable = 1'b1;
    logic             history_load = 1'b0;
    logic [1:0]       cursor = 2'd0;
    logic [NL*CW-1:0] guess_rgb = '0;
    logic [NL*CW-1:0] history_rgb = '0;
    logic [PB-1:0]    brightness = 2'b11;
    logic [NL*CW-1:0] rgb_out;
    logic             reveal_busy;
    logic [8:0]       rgb_out3;
    logic             busy3;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_state = 0;     // 0 guess, 1 reveal, 2 history
    int   guess_entry = 0;
    int   rev_start = 0;
    int   pwm_base = 0;
    int   busy_cnt;

    always #5 clk = ~clk;

    rgb_led_array_ctrl #(
        .NUM_LEDS    (NL),
        .COLOR_W     (CW),
        .BLINK_HALF  (BH),
        .REVEAL_STEP (RS),
        .PWM_BITS    (PB)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .blink_enable (blink_enable),
        .cursor       (cursor),
        .guess_rgb    (guess_rgb),
        .history_rgb  (history_rgb),
        .history_load (history_load),
        .brightness   (brightness),
        .rgb_out      (rgb_out),
        .reveal_busy  (reveal_busy)
    );

    // Three LEDs with a 2-bit cursor parked out of range
    rgb_led_array_ctrl #(
        .NUM_LEDS    (3),
        .COLOR_W     (CW),
        .BLINK_HALF  (BH),
        .REVEAL_STEP (RS),
        .PWM_BITS    (PB)
    ) u_dut3 (
        .clk          (clk),
        .rst          (rst),
        .blink_enable (1'b1),
        .cursor       (2'd3),
        .guess_rgb    (9'h1FF),
        .history_rgb  (9'h000),
        .history_load (1'b0),
        .brightness   (2'b11),
        .rgb_out      (rgb_out3),
        .reveal_busy  (busy3)
    );

    task automatic tick();
        exp_t       e;
        logic [8:0] e3;
        logic [2:0] col;
        int         pc, rc, ns;
        bit         pon, bon;
        e.rgb = '0;
        e3    = rst ? 9'h000 : 9'h1FF;
        ns    = m_state;
        if (rst) begin
            ns          = 0;
            guess_entry = cyc + 1;
            pwm_base    = cyc + 1;
        end else begin
            pc  = (cyc - pwm_base) % 3;
            pon = pc < int'(brightness);
            bon = (((cyc - guess_entry) / BH) % 2) == 0;
            rc  = (cyc - rev_start) / RS + 1;
            for (int i = 0; i < NL; i++) begin
                case (m_state)
                    0:       col = (i == int'(cursor) && !bon) ? 3'b000 : guess_rgb[i*CW +: CW];
                    1:       col = (i < rc) ? history_rgb[i*CW +: CW] : 3'b000;
                    default: col = history_rgb[i*CW +: CW];
                endcase
                if (pon) e.rgb[i*CW +: CW] = col;
            end
            if (blink_enable) begin
                if (m_state != 0) guess_entry = cyc + 1;
                ns = 0;
            end else if (history_load) begin
                ns        = 1;
                rev_start = cyc + 1;
            end else if (m_state == 0) begin
                ns = 2;
            end else if (m_state == 1 && (cyc - rev_start) == NL*RS - 1) begin
                ns = 2;
            end
        end
        e.busy = (ns == 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (rgb_out === e.rgb) else begin
            errors++;
            $error("FAIL rgb_out cyc=%0d got=%h exp=%h", cyc, rgb_out, e.rgb);
        end
        checks++;
        assert (reveal_busy === e.busy) else begin
            errors++;
            $error("FAIL reveal_busy cyc=%0d got=%b exp=%b", cyc, reveal_busy, e.busy);
        end
        checks++;
        assert (rgb_out3 === e3 && busy3 === 1'b0) else begin
            errors++;
            $error("FAIL cursor_oob cyc=%0d got=%h/%b exp=%h/0", cyc, rgb_out3, busy3, e3);
        end
        m_state = ns;
        cyc++;
    endtask

    task automatic reveal_and_count(output int n);
        n = 0;
        history_load = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            history_load = 1'b0;
            if (reveal_busy === 1'b1) n++;
        end
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // GUESS, full brightness, cursor blinking on LED2
        cursor       = 2'd2;
        guess_rgb    = 12'b101_101_101_101;
        brightness   = 2'b11;
        blink_enable = 1'b1;
        repeat (20) tick();

        // 1-of-3 PWM duty
        guess_rgb  = 12'hFFF;
        brightness = 2'b01;
        repeat (9) tick();

        // HISTORY then full reveal
        brightness   = 2'b11;
        history_rgb  = 12'b111_100_010_001;
        blink_enable = 1'b0;
        repeat (2) tick();
        reveal_and_count(busy_cnt);
        checks++;
        assert (busy_cnt == 12) else begin
            errors++;
            $error("FAIL reveal_len got=%0d exp=12", busy_cnt);
        end
        checks++;
        assert (rgb_out === history_rgb) else begin
            errors++;
            $error("FAIL reveal_final got=%h exp=%h", rgb_out, history_rgb);
        end

        // Restart the animation at rc=3
        history_load = 1'b1;
        tick();
        history_load = 1'b0;
        repeat (6) tick();
        reveal_and_count(busy_cnt);
        checks++;
        assert (busy_cnt == 12) else begin
            errors++;
            $error("FAIL restart_len got=%0d exp=12", busy_cnt);
        end

        // Abort a reveal by going back to GUESS
        history_load = 1'b1;
        tick();
        history_load = 1'b0;
        repeat (4) tick();
        blink_enable = 1'b1;
        guess_rgb    = 12'b011_110_101_001;
        cursor       = 2'd1;
        tick();
        checks++;
        assert (reveal_busy === 1'b0) else begin
            errors++;
            $error("FAIL abort_busy got=%b exp=0", reveal_busy);
        end
        tick();
        checks++;
        assert (rgb_out === guess_rgb) else begin
            errors++;
            $error("FAIL abort_cursor got=%h exp=%h", rgb_out, guess_rgb);
        end
        repeat (10) tick();

        // Reset in the middle of a reveal
        blink_enable = 1'b0;
        history_load = 1'b1;
        tick();
        history_load = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++;
        assert (rgb_out === '0 && reveal_busy === 1'b0) else begin
            errors++;
            $error("FAIL reset_mid got=%h/%b exp=000/0", rgb_out, reveal_busy);
        end
        rst = 1'b0;
        blink_enable = 1'b1;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_led_array_ctrl.md
# rgb_led_array_ctrl

Parametrised output stage for the game's RGB LED array. It drives NUM_LEDS RGB LEDs in one of two modes: GUESS mode shows the guess bus with the cursor LED blinking at a programmable rate, and HISTORY mode shows the history bus with an optional LED-by-LED reveal animation. A global PWM brightness control applies to every LED. It sits between the game FSM and the board pins, replacing the fixed 4-LED driver.

## Interface
Parameters:
- NUM_LEDS, 4, number of RGB LEDs (≥2)
- COLOR_W, 3, bits per LED (R,G,B)
- BLINK_HALF, 25_000_000, cycles per blink half-period (≥1)
- REVEAL_STEP, 50_000_000, cycles each reveal step is held (≥1)
- PWM_BITS, 4, brightness resolution

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- blink_enable  in  1  1 = GUESS mode, 0 = HISTORY mode
- cursor  in  $clog2(NUM_LEDS)  index of the LED that blinks in GUESS mode
- guess_rgb  in  NUM_LEDS*COLOR_W  guess colours; LED i is bits [i*COLOR_W +: COLOR_W]
- history_rgb  in  NUM_LEDS*COLOR_W  history colours, same packing
- history_load  in  1  single-cycle pulse that starts a reveal animation; honoured only when blink_enable=0
- brightness  in  PWM_BITS  duty value; 0 = dark, all-ones = full on
- rgb_out  out  NUM_LEDS*COLOR_W  registered LED drive
- reveal_busy  out  1  high while in the REVEAL state

## Operation
- State machine with three states: GUESS, REVEAL, HISTORY. Reset state is GUESS.
  - Any state with blink_enable=1 → GUESS. This aborts a reveal in progress.
  - GUESS with blink_enable=0 → HISTORY. Transition is immediate, with no animation.
  - GUESS/HISTORY with blink_enable=0 and history_load=1 → REVEAL, with rc=1.
  - REVEAL: step counter counts 0..REVEAL_STEP-1.
    - At the terminal count, if rc<NUM_LEDS then rc+1.
    - At the terminal count, if rc==NUM_LEDS then → HISTORY.
    - history_load during REVEAL restarts the animation: rc=1, step counter=0.
- Pre-PWM colour per LED i:
  - GUESS: guess_rgb[i], except that LED i==cursor is forced to 0 while blink_on=0.
    - A cursor value ≥ NUM_LEDS blanks nothing.
  - REVEAL: history_rgb[i] if i<rc, else 0.
  - HISTORY: history_rgb[i].
- Blink:
  - blink_cnt counts 0..BLINK_HALF-1 only in GUESS; blink_on toggles at the terminal count.
  - On every entry into GUESS (and at reset): blink_cnt=0 and blink_on=1, so the cursor is visible first.
- PWM:
  - pwm_cnt runs freely 0..2^PWM_BITS-2 and then wraps to 0, giving a period of 2^PWM_BITS-1 cycles.
  - pwm_on = (pwm_cnt < brightness).
  - When pwm_on=0, all of rgb_out is 0.
  - brightness=all-ones gives constant on; brightness=0 gives constant off.
- Data inputs are not latched; they are sampled every cycle.

## Timing
- Reset values:
  - rgb_out=0, reveal_busy=0, state=GUESS.
  - blink_on=1, and blink_cnt, pwm_cnt, step counter = 0, rc=0.
- Latency:
  - rgb_out is registered. Its value in cycle t+1 is a function of the inputs and internal registers in cycle t.
  - A guess_rgb change therefore appears one cycle later.
- Mode change: blink_enable edge in cycle t → new state in t+1 → matching rgb_out in t+2.
- history_load in cycle t:
  - reveal_busy=1 and rc=1 from t+1.
  - LED0 visible on rgb_out at t+2.
  - rc increments every REVEAL_STEP cycles.
  - reveal_busy falls NUM_LEDS*REVEAL_STEP cycles after t+1.
- Blink: the cursor is visible for BLINK_HALF cycles, then dark for BLINK_HALF cycles, repeating.
- Simultaneous events:
  - blink_enable=1 overrides history_load.
  - rst overrides everything.
  - Reset mid-reveal returns to GUESS with reveal_busy=0 on the next cycle.

## Structure
- Package rgb_led_pkg contains:
  - state enum (GUESS, REVEAL, HISTORY)
  - COLOR_OFF constant (all zeros)
  - colour-slice index helper function
- Sub-module pwm_gen (parameter PWM_BITS; ports clk, rst, brightness, pwm_on) holds the free-running counter and compare.
- Everything else lives in one module: FSM, blink counter, reveal counter, and the output mux/register.

## Test plan
Bench parameters: NUM_LEDS=4, COLOR_W=3, BLINK_HALF=4, REVEAL_STEP=3, PWM_BITS=2.

- Reset, full brightness (2'b11), GUESS, guess=all LEDs 3'b101, cursor=2 → rgb_out LED2 equals 101 for 4 cycles, 000 for 4 cycles, and so on; the other LEDs stay constant at 101.
- brightness=2'b01 with all LEDs 3'b111 → over each 3-cycle PWM period rgb_out is 111 for 1 cycle and 0 for 2 cycles.
- blink_enable=0 with history=LED0..3 {001,010,100,111}, pulse history_load → reveal_busy=1 for 12 cycles; LEDs turn on cumulatively, one more every 3 cycles; final rgb_out equals the history bus.
- Mid-reveal, set blink_enable=1 → reveal_busy=0 the next cycle; guess colours appear with the cursor visible (blink_on=1).
- Pulse history_load again at rc=3 → rc restarts at 1; the full 12-cycle reveal repeats.
- cursor=3'b... out-of-range case (NUM_LEDS=3, cursor=3) → no LED ever blanks; assert rst mid-stream → rgb_out=0 on the next cycle.
